serial_paralelo_rx: RTL



---
 rtl/serial_paralelo_rx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_paralelo_rx.sv
// Serial receiver: COM hunt, byte alignment and {valid, byte} word rebuild.
// Optional link-drop on idle is enabled with `define RX_IDLE_TIMEOUT_EN.
module serial_paralelo_rx #(
    parameter logic [7:0] COM_BYTE     = 8'hBC,
    parameter int         COM_COUNT    = 4,
    parameter int         IDLE_TIMEOUT = 16
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [8:0] paralelo_out,
    output logic       byte_stb,
    output logic       sync,
    output logic       active
);

    typedef enum logic [1:0] {
        S_HUNT   = 2'b00,
        S_SYNC   = 2'b01,
        S_ACTIVE = 2'b10
    } state_t;

    localparam logic [3:0] COM_N = 4'(COM_COUNT);

    if (COM_COUNT < 1 || COM_COUNT > 15) begin : g_bad_com_count
        $error("COM_COUNT must be in 1..15");
    end
    if (IDLE_TIMEOUT < 2 || IDLE_TIMEOUT > 255) begin : g_bad_idle_timeout
        $error("IDLE_TIMEOUT must be in 2..255");
    end

    state_t     state, state_n;
    logic [6:0] sr;
    logic [7:0] cand;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [3:0] com_cnt, com_cnt_n;
    logic [8:0] out_n;
    logic       stb_n;
    logic       boundary;
    logic       is_com;

`ifdef RX_IDLE_TIMEOUT_EN
    localparam logic [7:0] IDLE_N = 8'(IDLE_TIMEOUT);
    logic [7:0] idle_cnt, idle_cnt_n;
`endif

    // Only the last 7 bits are kept; the 8th comes straight from data_in.
    assign cand     = {sr, data_in};
    assign is_com   = (cand == COM_BYTE);
    assign boundary = (bit_cnt == 3'd7);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt + 3'd1;
        com_cnt_n  = com_cnt;
        out_n      = paralelo_out;
        stb_n      = 1'b0;
`ifdef RX_IDLE_TIMEOUT_EN
        idle_cnt_n = idle_cnt;
`endif
        case (state)
            S_HUNT: begin
                bit_cnt_n = 3'd0;
                if (is_com) begin
                    com_cnt_n = 4'd1;
                    state_n   = (COM_N == 4'd1) ? S_ACTIVE : S_SYNC;
                end
            end
            S_SYNC: begin
                if (boundary) begin
                    if (!is_com) begin
                        state_n   = S_HUNT;
                        com_cnt_n = 4'd0;
                    end else if (com_cnt + 4'd1 == COM_N) begin
                        state_n   = S_ACTIVE;
                        com_cnt_n = 4'd0;
                    end else begin
                        com_cnt_n = com_cnt + 4'd1;
                    end
                end
            end
            S_ACTIVE: begin
                if (boundary) begin
                    stb_n = 1'b1;
                    if (is_com) begin
                        out_n = {1'b0, COM_BYTE};
`ifdef RX_IDLE_TIMEOUT_EN
                        if (idle_cnt + 8'd1 == IDLE_N) begin
                            state_n    = S_HUNT;
                            idle_cnt_n = 8'd0;
                        end else begin
                            idle_cnt_n = idle_cnt + 8'd1;
                        end
`endif
                    end else begin
                        out_n = {1'b1, cand};
`ifdef RX_IDLE_TIMEOUT_EN
                        idle_cnt_n = 8'd0;
`endif
                    end
                end
            end
            default: begin
                state_n   = S_HUNT;
                bit_cnt_n = 3'd0;
                com_cnt_n = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state        <= S_HUNT;
            sr           <= 7'd0;
            bit_cnt      <= 3'd0;
            com_cnt      <= 4'd0;
            paralelo_out <= 9'h000;
            byte_stb     <= 1'b0;
        end else begin
            state        <= state_n;
            sr           <= cand[6:0];
            bit_cnt      <= bit_cnt_n;
            com_cnt      <= com_cnt_n;
            paralelo_out <= out_n;
            byte_stb     <= stb_n;
        end
    end

`ifdef RX_IDLE_TIMEOUT_EN
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            idle_cnt <= 8'd0;
        end else begin
            idle_cnt <= idle_cnt_n;
        end
    end
`endif

    assign sync   = (state == S_SYNC) || (state == S_ACTIVE);
    assign active = (state == S_ACTIVE);

endmodule
